// File: rtl/load_count_demux.sv
// Load-bus receive endpoint: 2-entry input FIFO feeding four
// saturating 4-bit down-counters with per-counter expiry pulses.
module load_count_demux #(
    parameter int DATA_W     = 4,
    parameter int SEL_W      = 2,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [DATA_W+SEL_W-1:0]          Z,
    input  logic                             src,
    input  logic                             load_valid,
    output logic                             load_ready,
    input  logic                             hold,
    input  logic [(2**SEL_W)-1:0]            count_en,
    output logic [(2**SEL_W)*DATA_W-1:0]     count_q,
    output logic [(2**SEL_W)-1:0]            zero,
    output logic [(2**SEL_W)-1:0]            last_src,
    output logic [(2**SEL_W)-1:0]            expired,
    output logic [1:0]                       fifo_level
);

    localparam int NREG = 2 ** SEL_W;
    localparam int EW   = DATA_W + SEL_W + 1;

    typedef logic [EW-1:0] entry_t;

    entry_t            fifo_q [FIFO_DEPTH];
    entry_t            fifo_d [FIFO_DEPTH];
    logic [1:0]        level_q, level_d;
    logic [DATA_W-1:0] cnt_q [NREG];
    logic [DATA_W-1:0] cnt_d [NREG];
    logic [NREG-1:0]   src_q, src_d;
    logic [NREG-1:0]   exp_q, exp_d;

    logic              push, pop;
    logic [1:0]        base;
    logic [SEL_W-1:0]  head_sel;
    logic [DATA_W-1:0] head_val;
    logic              head_src;

    assign load_ready = (level_q != 2'd2);
    assign push       = load_valid & load_ready;
    assign pop        = (level_q != 2'd0) & ~hold;
    assign head_src   = fifo_q[0][0];
    assign head_sel   = fifo_q[0][SEL_W:1];
    assign head_val   = fifo_q[0][EW-1:SEL_W+1];

    // Shift FIFO: slot 0 is always the head, new word lands after survivors
    always_comb begin
        fifo_d = fifo_q;
        base   = level_q - {1'b0, pop};
        if (pop) begin
            fifo_d[0] = fifo_q[1];
        end
        if (push) begin
            fifo_d[base[0]] = {Z, src};
        end
        level_d = base + {1'b0, push};
    end

    always_comb begin
        for (int k = 0; k < NREG; k++) begin
            cnt_d[k] = cnt_q[k];
            src_d[k] = src_q[k];
            exp_d[k] = 1'b0;
            if (pop && head_sel == SEL_W'(k)) begin
                cnt_d[k] = head_val;
                src_d[k] = head_src;
            end else if (count_en[k] && cnt_q[k] != '0) begin
                cnt_d[k] = cnt_q[k] - 1'b1;
                exp_d[k] = (cnt_q[k] == DATA_W'(1));
            end
        end
    end

    always_comb begin
        count_q = '0;
        zero    = '0;
        for (int k = 0; k < NREG; k++) begin
            count_q[k*DATA_W +: DATA_W] = cnt_q[k];
            zero[k] = (cnt_q[k] == '0);
        end
    end

    assign last_src   = src_q;
    assign expired    = exp_q;
    assign fifo_level = level_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
            for (int k = 0; k < NREG; k++) begin
                cnt_q[k] <= '0;
            end
            level_q <= '0;
            src_q   <= '0;
            exp_q   <= '0;
        end else begin
            fifo_q  <= fifo_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            src_q   <= src_d;
            exp_q   <= exp_d;
        end
    end

endmodule

// File: tb/tb_load_count_demux.sv
// Scoreboard bench for load_count_demux: stimulus queues expected
// snapshots, a negedge monitor pops and compares them.
module tb_load_count_demux;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  Z;
    logic        src;
    logic        load_valid;
    logic        load_ready;
    logic        hold;
    logic [3:0]  count_en;
    logic [15:0] count_q;
    logic [3:0]  zero;
    logic [3:0]  last_src;
    logic [3:0]  expired;
    logic [1:0]  fifo_level;

    typedef struct packed {
        logic [15:0] cnt;
        logic [3:0]  zro;
        logic [3:0]  lsrc;
        logic [3:0]  exp;
        logic [1:0]  lvl;
        logic        rdy;
    } snap_t;

    snap_t exp_q[$];
    string name_q[$];
    int    errors = 0;
    int    checks = 0;

    load_count_demux dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .Z          (Z),
        .src        (src),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .hold       (hold),
        .count_en   (count_en),
        .count_q    (count_q),
        .zero       (zero),
        .last_src   (last_src),
        .expired    (expired),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] zf(input logic [15:0] c);
        logic [3:0] r;
        for (int k = 0; k < 4; k++) r[k] = (c[4*k +: 4] == 4'h0);
        return r;
    endfunction

    task automatic expect_snap(input string nm, input logic [15:0] c,
                               input logic [3:0] ls, input logic [3:0] ex,
                               input logic [1:0] lv, input logic rd);
        snap_t s;
        s.cnt  = c;
        s.zro  = zf(c);
        s.lsrc = ls;
        s.exp  = ex;
        s.lvl  = lv;
        s.rdy  = rd;
        exp_q.push_back(s);
        name_q.push_back(nm);
    endtask

    // Drive one cycle of inputs, then queue the state expected after the edge
    task automatic step(input string nm, input logic [5:0] z, input logic s,
                        input logic v, input logic h, input logic [3:0] en,
                        input logic [15:0] c, input logic [3:0] ls,
                        input logic [3:0] ex, input logic [1:0] lv,
                        input logic rd);
        Z = z; src = s; load_valid = v; hold = h; count_en = en;
        @(posedge clk);
        #1;
        expect_snap(nm, c, ls, ex, lv, rd);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            snap_t e, a;
            string nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            a  = {count_q, zero, last_src, expired, fifo_level, load_ready};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL %s: got cnt=%h zero=%b lsrc=%b exp=%b lvl=%0d rdy=%b, want cnt=%h zero=%b lsrc=%b exp=%b lvl=%0d rdy=%b",
                         nm, a.cnt, a.zro, a.lsrc, a.exp, a.lvl, a.rdy,
                         e.cnt, e.zro, e.lsrc, e.exp, e.lvl, e.rdy);
            end
        end
    end

    initial begin
        rst_n = 1'b0; Z = '0; src = 1'b0; load_valid = 1'b0;
        hold = 1'b0; count_en = '0;
        expect_snap("reset", 16'h0000, 4'b0000, 4'b0000, 2'd0, 1'b1);
        #12 rst_n = 1'b1;

        step("acceptA",   6'h2A, 1, 1, 0, 4'b0000, 16'h0000, 4'b0000, 4'b0000, 2'd1, 1);
        step("commitA",   6'h00, 0, 0, 0, 4'b0000, 16'h0A00, 4'b0100, 4'b0000, 2'd0, 1);
        step("hold_w0",   6'h04, 0, 1, 1, 4'b0000, 16'h0A00, 4'b0100, 4'b0000, 2'd1, 1);
        step("hold_w1",   6'h09, 1, 1, 1, 4'b0000, 16'h0A00, 4'b0100, 4'b0000, 2'd2, 0);
        step("hold_stall",6'h0F, 0, 1, 1, 4'b0000, 16'h0A00, 4'b0100, 4'b0000, 2'd2, 0);
        step("rel_c0",    6'h0F, 0, 1, 0, 4'b0000, 16'h0A01, 4'b0100, 4'b0000, 2'd1, 1);
        step("rel_c1_acc",6'h0F, 0, 1, 0, 4'b0000, 16'h0A21, 4'b0110, 4'b0000, 2'd1, 1);
        step("rel_c3",    6'h00, 0, 0, 0, 4'b0000, 16'h3A21, 4'b0110, 4'b0000, 2'd0, 1);
        step("acc3_c1",   6'h0D, 0, 1, 0, 4'b0000, 16'h3A21, 4'b0110, 4'b0000, 2'd1, 1);
        step("loadwin1",  6'h00, 0, 0, 0, 4'b0010, 16'h3A31, 4'b0100, 4'b0000, 2'd0, 1);
        step("dec_2",     6'h00, 0, 0, 0, 4'b0010, 16'h3A21, 4'b0100, 4'b0000, 2'd0, 1);
        step("dec_1",     6'h00, 0, 0, 0, 4'b0010, 16'h3A11, 4'b0100, 4'b0000, 2'd0, 1);
        step("dec_0_exp", 6'h00, 0, 0, 0, 4'b0010, 16'h3A01, 4'b0100, 4'b0010, 2'd0, 1);
        step("sat_0",     6'h00, 0, 0, 0, 4'b0010, 16'h3A01, 4'b0100, 4'b0000, 2'd0, 1);
        step("acc5_c0",   6'h14, 1, 1, 0, 4'b0000, 16'h3A01, 4'b0100, 4'b0000, 2'd1, 1);
        step("loadwin0",  6'h00, 0, 0, 0, 4'b0001, 16'h3A05, 4'b0101, 4'b0000, 2'd0, 1);
        step("par_dec",   6'h00, 0, 0, 0, 4'b1111, 16'h2904, 4'b0101, 4'b0000, 2'd0, 1);
        step("tput_a",    6'h1D, 1, 1, 0, 4'b0000, 16'h2904, 4'b0101, 4'b0000, 2'd1, 1);
        step("tput_b",    6'h1A, 0, 1, 0, 4'b0000, 16'h2974, 4'b0111, 4'b0000, 2'd1, 1);
        step("tput_end",  6'h00, 0, 0, 0, 4'b0000, 16'h2674, 4'b0011, 4'b0000, 2'd0, 1);
        step("fill_1",    6'h04, 0, 1, 1, 4'b0000, 16'h2674, 4'b0011, 4'b0000, 2'd1, 1);
        step("fill_2",    6'h09, 1, 1, 1, 4'b0000, 16'h2674, 4'b0011, 4'b0000, 2'd2, 0);

        // Async reset asserted between edges; checked before the next edge
        load_valid = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        expect_snap("async_rst", 16'h0000, 4'b0000, 4'b0000, 2'd0, 1'b1);
        @(negedge clk);
        #2 rst_n = 1'b1;
        hold = 1'b0;

        step("post_rst",  6'h0D, 1, 1, 0, 4'b0000, 16'h0000, 4'b0000, 4'b0000, 2'd1, 1);
        step("post_c1",   6'h00, 0, 0, 0, 4'b0000, 16'h0030, 4'b0010, 4'b0000, 2'd0, 1);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            errors++;
            checks++;
            $display("FAIL drain: got %0d pending, want 0", exp_q.size());
        end
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
